// File: rtl/bp_gshare_ras.sv
// bp_gshare_ras: gshare direction predictor, 2-way BTB and optional return
// address stack.
//
// The prediction is combinational from pc_f_i and the current state; training
// from the EX stage lands on the rising clock edge and is visible next cycle.
//
// Optional feature macro: BP_RAS_EN. When it is defined, a circular return
// stack supplies return targets. When it is not defined, returns are predicted
// from the BTB target like any other entry.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   pc_f_i               fetch PC to predict
//   pc_ex_i              PC of the resolving control-flow instruction
//   is_branch_i          one resolved control-flow instruction this cycle
//   update_type_i        00 cond, 01 jump, 10 call, 11 return
//   branch_taken_ex_i    resolved direction
//   branch_target_ex_i   resolved target
//   predict_taken_o      predicted redirect
//   predict_target_o     predicted target (0 on a BTB miss)
//   predict_hit_o        BTB hit for pc_f_i
module bp_gshare_ras #(
  parameter int unsigned INDEX_BITS     = 10,
  parameter int unsigned GHR_BITS       = 8,
  parameter int unsigned BTB_INDEX_BITS = 8,
  parameter int unsigned TAG_BITS       = 12,
  parameter int unsigned RAS_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc_ex_i,
  input  logic        is_branch_i,
  input  logic [1:0]  update_type_i,
  input  logic        branch_taken_ex_i,
  input  logic [31:0] branch_target_ex_i,
  output logic        predict_taken_o,
  output logic [31:0] predict_target_o,
  output logic        predict_hit_o
);

  typedef enum logic [1:0] {
    T_COND = 2'b00,
    T_JUMP = 2'b01,
    T_CALL = 2'b10,
    T_RET  = 2'b11
  } br_type_e;

  localparam int unsigned CTRS = 1 << INDEX_BITS;
  localparam int unsigned SETS = 1 << BTB_INDEX_BITS;

  logic [1:0]          ctr_q     [CTRS];
  logic [GHR_BITS-1:0] ghr_q;
  logic                btb_val_q [2][SETS];
  logic [TAG_BITS-1:0] btb_tag_q [2][SETS];
  logic [31:0]         btb_tgt_q [2][SETS];
  br_type_e            btb_typ_q [2][SETS];
  logic                btb_lru_q [SETS];

  logic [INDEX_BITS-1:0] ghr_ext;
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_BITS-1:0] = ghr_q;
  end

  logic unused_pc;
  assign unused_pc = ^{pc_f_i, pc_ex_i};

  // ---------------- fetch-side lookup ----------------
  logic [BTB_INDEX_BITS-1:0] f_set;
  logic [TAG_BITS-1:0]       f_tag;
  logic [INDEX_BITS-1:0]     f_idx;
  logic                      f_hit0, f_hit1, f_hit, f_way;

  assign f_set  = pc_f_i[BTB_INDEX_BITS+1:2];
  assign f_tag  = pc_f_i[BTB_INDEX_BITS+TAG_BITS+1:BTB_INDEX_BITS+2];
  assign f_idx  = pc_f_i[INDEX_BITS+1:2] ^ ghr_ext;
  assign f_hit0 = btb_val_q[0][f_set] && (btb_tag_q[0][f_set] == f_tag);
  assign f_hit1 = btb_val_q[1][f_set] && (btb_tag_q[1][f_set] == f_tag);
  assign f_hit  = f_hit0 || f_hit1;
  assign f_way  = f_hit0 ? 1'b0 : 1'b1;

  // ---------------- update-side lookup ----------------
  br_type_e                  u_type;
  logic [BTB_INDEX_BITS-1:0] u_set;
  logic [TAG_BITS-1:0]       u_tag;
  logic [INDEX_BITS-1:0]     u_idx;
  logic [1:0]                u_ctr;
  logic                      u_hit0, u_hit1, u_hit, u_way, u_alloc_way, u_wr;

  assign u_type = br_type_e'(update_type_i);
  assign u_set  = pc_ex_i[BTB_INDEX_BITS+1:2];
  assign u_tag  = pc_ex_i[BTB_INDEX_BITS+TAG_BITS+1:BTB_INDEX_BITS+2];
  assign u_idx  = pc_ex_i[INDEX_BITS+1:2] ^ ghr_ext;
  assign u_ctr  = ctr_q[u_idx];
  assign u_hit0 = btb_val_q[0][u_set] && (btb_tag_q[0][u_set] == u_tag);
  assign u_hit1 = btb_val_q[1][u_set] && (btb_tag_q[1][u_set] == u_tag);
  assign u_hit  = u_hit0 || u_hit1;
  // Invalid way 0 first, then invalid way 1, then the LRU way.
  assign u_alloc_way = !btb_val_q[0][u_set] ? 1'b0 :
                       !btb_val_q[1][u_set] ? 1'b1 : btb_lru_q[u_set];
  assign u_way  = u_hit ? (u_hit0 ? 1'b0 : 1'b1) : u_alloc_way;
  assign u_wr   = is_branch_i && (u_hit || branch_taken_ex_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
      for (int unsigned i = 0; i < CTRS; i++) ctr_q[i] <= 2'b01;
      for (int unsigned s = 0; s < SETS; s++) begin
        btb_val_q[0][s] <= 1'b0;
        btb_val_q[1][s] <= 1'b0;
        btb_lru_q[s]    <= 1'b0;
      end
    end else if (is_branch_i) begin
      if (u_type == T_COND) begin
        if (branch_taken_ex_i && u_ctr != 2'b11) ctr_q[u_idx] <= u_ctr + 2'b01;
        else if (!branch_taken_ex_i && u_ctr != 2'b00) ctr_q[u_idx] <= u_ctr - 2'b01;
        ghr_q <= GHR_BITS'({ghr_q, branch_taken_ex_i});
      end
      if (u_wr) begin
        btb_val_q[u_way][u_set] <= 1'b1;
        btb_tag_q[u_way][u_set] <= u_tag;
        btb_tgt_q[u_way][u_set] <= branch_target_ex_i;
        btb_typ_q[u_way][u_set] <= u_type;
        btb_lru_q[u_set]        <= ~u_way;
      end
    end
  end

`ifdef BP_RAS_EN
  localparam int unsigned PTR_BITS = $clog2(RAS_DEPTH);
  localparam logic [PTR_BITS:0] RAS_FULL = (PTR_BITS+1)'(RAS_DEPTH);

  logic [31:0]         ras_q [RAS_DEPTH];
  logic [PTR_BITS-1:0] ras_ptr_q;
  logic [PTR_BITS:0]   ras_cnt_q;
  logic [31:0]         ras_top;
  logic                ras_push, ras_pop;

  // ras_ptr_q is the next write slot; the power-of-two depth makes the
  // pointer wrap so a push on a full stack overwrites the oldest entry.
  assign ras_top  = ras_q[ras_ptr_q - PTR_BITS'(1)];
  assign ras_push = is_branch_i && (u_type == T_CALL);
  assign ras_pop  = is_branch_i && (u_type == T_RET);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (ras_push) begin
      ras_ptr_q <= ras_ptr_q + PTR_BITS'(1);
      if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + (PTR_BITS+1)'(1);
    end else if (ras_pop && ras_cnt_q != '0) begin
      ras_ptr_q <= ras_ptr_q - PTR_BITS'(1);
      ras_cnt_q <= ras_cnt_q - (PTR_BITS+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && ras_push) ras_q[ras_ptr_q] <= pc_ex_i + 32'd4;
  end
`endif

  // ---------------- prediction ----------------
  always_comb begin
    predict_hit_o    = f_hit;
    predict_taken_o  = 1'b0;
    predict_target_o = '0;
    if (f_hit) begin
      predict_taken_o  = (btb_typ_q[f_way][f_set] != T_COND) || ctr_q[f_idx][1];
      predict_target_o = btb_tgt_q[f_way][f_set];
`ifdef BP_RAS_EN
      if (btb_typ_q[f_way][f_set] == T_RET && ras_cnt_q != '0)
        predict_target_o = ras_top;
`endif
    end
  end

endmodule

// File: tb/tb_bp_gshare_ras.sv
// Directed bench for bp_gshare_ras: reset state, gshare training, BTB LRU
// replacement, call/return prediction and (with BP_RAS_EN) stack wraparound.
module tb_bp_gshare_ras;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_f_i;
  logic [31:0] pc_ex_i;
  logic        is_branch_i;
  logic [1:0]  update_type_i;
  logic        branch_taken_ex_i;
  logic [31:0] branch_target_ex_i;
  logic        predict_taken_o;
  logic [31:0] predict_target_o;
  logic        predict_hit_o;

  int unsigned nchecks = 0;
  int unsigned nerr    = 0;

  always #5 clk = ~clk;

  bp_gshare_ras #(
    .INDEX_BITS(10),
    .GHR_BITS(8),
    .BTB_INDEX_BITS(8),
    .TAG_BITS(12),
    .RAS_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_f_i(pc_f_i),
    .pc_ex_i(pc_ex_i),
    .is_branch_i(is_branch_i),
    .update_type_i(update_type_i),
    .branch_taken_ex_i(branch_taken_ex_i),
    .branch_target_ex_i(branch_target_ex_i),
    .predict_taken_o(predict_taken_o),
    .predict_target_o(predict_target_o),
    .predict_hit_o(predict_hit_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] ty,
                     input logic tk, input logic [31:0] tgt);
    pc_ex_i            = pc;
    update_type_i      = ty;
    branch_taken_ex_i  = tk;
    branch_target_ex_i = tgt;
    is_branch_i        = 1'b1;
    @(posedge clk);
    #1;
    is_branch_i = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    pc_f_i = pc;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; pc_f_i = '0; pc_ex_i = '0; is_branch_i = 1'b0;
    update_type_i = 2'b00; branch_taken_ex_i = 1'b0; branch_target_ex_i = '0;
    @(posedge clk);
    do_reset();

    // Reset state
    look(32'h100);
    chk("rst_taken",  32'(predict_taken_o), 32'd0);
    chk("rst_hit",    32'(predict_hit_o),   32'd0);
    chk("rst_target", predict_target_o,     32'd0);
    look(32'h900);
    chk("rst_hit_b",  32'(predict_hit_o),   32'd0);

    // Gshare: taken updates at 0x100 walk the GHR 0,1,3,..,0xFF; the fetch
    // index first lands on an already-trained counter after the 9th update.
    for (int i = 1; i <= 9; i++) begin
      upd(32'h100, 2'b00, 1'b1, 32'h200);
      look(32'h100);
      chk("gs_hit",    32'(predict_hit_o),   32'd1);
      chk("gs_target", predict_target_o,     32'h200);
      chk($sformatf("gs_taken_%0d", i), 32'(predict_taken_o), (i == 9) ? 32'd1 : 32'd0);
    end

    // Inactive update must not decrement the counter or shift the GHR
    pc_ex_i = 32'h100; update_type_i = 2'b00; branch_taken_ex_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    look(32'h100);
    chk("idle_taken", 32'(predict_taken_o), 32'd1);

    // Reset wins over a simultaneous update
    pc_ex_i = 32'h700; update_type_i = 2'b01; branch_taken_ex_i = 1'b1;
    branch_target_ex_i = 32'h777; is_branch_i = 1'b1;
    do_reset();
    is_branch_i = 1'b0;
    look(32'h100);
    chk("rprio_hit_a", 32'(predict_hit_o), 32'd0);
    look(32'h700);
    chk("rprio_hit_b", 32'(predict_hit_o), 32'd0);
    chk("rprio_tgt",   predict_target_o,   32'd0);

    // BTB replacement in set 0
    upd(32'h1000, 2'b01, 1'b1, 32'h1111);
    upd(32'h2000, 2'b01, 1'b1, 32'h2222);
    upd(32'h3000, 2'b01, 1'b1, 32'h3333);
    look(32'h1000);
    chk("ev_1000_hit", 32'(predict_hit_o), 32'd0);
    look(32'h2000);
    chk("ev_2000_hit", 32'(predict_hit_o),   32'd1);
    chk("ev_2000_tgt", predict_target_o,     32'h2222);
    chk("ev_2000_tk",  32'(predict_taken_o), 32'd1);
    look(32'h3000);
    chk("ev_3000_hit", 32'(predict_hit_o), 32'd1);
    chk("ev_3000_tgt", predict_target_o,   32'h3333);
    // Hit on way 1 makes way 0 (0x3000) the victim for the next allocation
    upd(32'h2000, 2'b01, 1'b1, 32'h2444);
    upd(32'h1000, 2'b01, 1'b1, 32'h1111);
    look(32'h3000);
    chk("lru_3000_hit", 32'(predict_hit_o), 32'd0);
    look(32'h2000);
    chk("lru_2000_tgt", predict_target_o,   32'h2444);
    look(32'h1000);
    chk("lru_1000_tgt", predict_target_o,   32'h1111);
    // Not-taken miss does not allocate
    upd(32'h5000, 2'b00, 1'b0, 32'h5555);
    look(32'h5000);
    chk("nt_no_alloc", 32'(predict_hit_o), 32'd0);

    // Call / return
    do_reset();
    upd(32'h900, 2'b11, 1'b1, 32'hA00);
    upd(32'h400, 2'b10, 1'b1, 32'h800);
    look(32'h400);
    chk("call_hit",   32'(predict_hit_o),   32'd1);
    chk("call_tk",    32'(predict_taken_o), 32'd1);
    chk("call_tgt",   predict_target_o,     32'h800);
    look(32'h900);
    chk("ret_tk",     32'(predict_taken_o), 32'd1);
`ifdef BP_RAS_EN
    chk("ret_tgt",    predict_target_o,     32'h404);
`else
    chk("ret_tgt",    predict_target_o,     32'hA00);
`endif
    upd(32'h900, 2'b11, 1'b1, 32'hA00);
    look(32'h900);
    chk("ret_after",  predict_target_o,     32'hA00);

`ifdef BP_RAS_EN
    // Nine calls into an eight-deep stack: the first one is lost
    do_reset();
    upd(32'h900, 2'b11, 1'b1, 32'hA00);
    for (int k = 1; k <= 9; k++) upd(32'h4000 + 32'(16 * k), 2'b10, 1'b1, 32'h8000);
    for (int j = 0; j < 8; j++) begin
      look(32'h900);
      chk($sformatf("ras_pop_%0d", j), predict_target_o, 32'h4000 + 32'(16 * (9 - j)) + 32'd4);
      upd(32'h900, 2'b11, 1'b1, 32'hA00);
    end
    look(32'h900);
    chk("ras_empty",  predict_target_o, 32'hA00);
    upd(32'h900, 2'b11, 1'b1, 32'hA00);
    look(32'h900);
    chk("ras_empty2", predict_target_o, 32'hA00);
`else
    // Without the stack, call/return only retrain the BTB
    upd(32'h900, 2'b11, 1'b1, 32'hB00);
    look(32'h900);
    chk("btb_ret_tgt",  predict_target_o,   32'hB00);
    upd(32'h4010, 2'b10, 1'b1, 32'h8000);
    look(32'h900);
    chk("btb_ret_keep", predict_target_o,   32'hB00);
    look(32'h4010);
    chk("btb_call_tgt", predict_target_o,   32'h8000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
